// File: rtl/mac_lookup_arb_if.sv
// Bundle between the ingress-port requesters, mac_lookup_arb and mac_mem.
//   Requester side: ireq, isa, ida (to arbiter); oack, odst_mask, otimeout (from arbiter).
//   mac_mem side:   omem_req, omem_pnum, omem_sa, omem_da (from arbiter);
//                   imem_pnum, imem_ready (to arbiter).
// Modports: slave  = arbiter view, master = environment view (requesters + mac_mem).
interface mac_lookup_arb_if #(
  parameter int unsigned pNUM_PORTS = 4,
  parameter int unsigned pMAC_WIDTH = 48
);
  localparam int unsigned pPNUM_W = $clog2(pNUM_PORTS);

  logic [pNUM_PORTS-1:0]            ireq;
  logic [pNUM_PORTS*pMAC_WIDTH-1:0] isa;
  logic [pNUM_PORTS*pMAC_WIDTH-1:0] ida;
  logic [pNUM_PORTS-1:0]            oack;
  logic [pNUM_PORTS-1:0]            odst_mask;
  logic                             otimeout;
  logic                             omem_req;
  logic [pPNUM_W-1:0]               omem_pnum;
  logic [pMAC_WIDTH-1:0]            omem_sa;
  logic [pMAC_WIDTH-1:0]            omem_da;
  logic [pNUM_PORTS-1:0]            imem_pnum;
  logic                             imem_ready;

  modport slave (
    input  ireq, isa, ida, imem_pnum, imem_ready,
    output oack, odst_mask, otimeout, omem_req, omem_pnum, omem_sa, omem_da
  );

  modport master (
    output ireq, isa, ida, imem_pnum, imem_ready,
    input  oack, odst_mask, otimeout, omem_req, omem_pnum, omem_sa, omem_da
  );
endinterface

// File: rtl/mac_lookup_arb.sv
// Round-robin arbiter sharing one mac_mem lookup port among pNUM_PORTS requesters.
// One lookup in flight at a time; a lookup that gets no imem_ready within the
// timeout window is answered with a flood mask and otimeout.
// Ports: iclk, irst (sync, active-high), bus (mac_lookup_arb_if.slave).
// Optional: define MAC_LOOKUP_ARB_STATS_EN to add saturating counters
//   olookup_cnt / otimeout_cnt (16 bit).
module mac_lookup_arb #(
  parameter int unsigned pNUM_PORTS = 4,
  parameter int unsigned pMAC_WIDTH = 48,
  parameter int unsigned pTIMEOUT   = 16
) (
  input  logic        iclk,
  input  logic        irst,
`ifdef MAC_LOOKUP_ARB_STATS_EN
  output logic [15:0] olookup_cnt,
  output logic [15:0] otimeout_cnt,
`endif
  mac_lookup_arb_if.slave bus
);
  localparam int unsigned pPNUM_W = $clog2(pNUM_PORTS);
  localparam int unsigned CNT_W   = $clog2(pTIMEOUT);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

  state_t                   state_q, state_d;
  logic [pPNUM_W-1:0]       ptr_q, ptr_d;
  logic [CNT_W-1:0]         cnt_q, cnt_d;
  logic [pPNUM_W-1:0]       grant_d;
  logic [pMAC_WIDTH-1:0]    sa_d, da_d;
  logic                     req_d, tout_d;
  logic [pNUM_PORTS-1:0]    ack_d, dst_d, gbit;
  logic [pPNUM_W-1:0]       sel;
  logic                     found;
  int unsigned              idx;

  // First requesting port at or after the RR pointer, wrapping.
  always_comb begin
    sel   = ptr_q;
    found = 1'b0;
    idx   = 0;
    for (int unsigned i = 0; i < pNUM_PORTS; i++) begin
      idx = 32'(ptr_q) + i;
      if (idx >= pNUM_PORTS) idx = idx - pNUM_PORTS;
      if (!found && bus.ireq[pPNUM_W'(idx)]) begin
        found = 1'b1;
        sel   = pPNUM_W'(idx);
      end
    end
  end

  // Next state and next values of all registered outputs.
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    cnt_d   = cnt_q;
    grant_d = bus.omem_pnum;
    sa_d    = bus.omem_sa;
    da_d    = bus.omem_da;
    req_d   = 1'b0;
    ack_d   = '0;
    dst_d   = '0;
    tout_d  = 1'b0;
    gbit    = pNUM_PORTS'(1) << bus.omem_pnum;
    unique case (state_q)
      IDLE: begin
        if (found) begin
          grant_d = sel;
          sa_d    = bus.isa[sel*pMAC_WIDTH +: pMAC_WIDTH];
          da_d    = bus.ida[sel*pMAC_WIDTH +: pMAC_WIDTH];
          req_d   = 1'b1;
          state_d = ISSUE;
        end
      end
      ISSUE: begin
        cnt_d   = '0;
        state_d = WAIT;
      end
      WAIT: begin
        // Ready wins over the timeout boundary; unknown DA floods; never hairpin.
        if (bus.imem_ready) begin
          ack_d   = gbit;
          dst_d   = ((bus.imem_pnum == '0) ? '1 : bus.imem_pnum) & ~gbit;
          state_d = RESP;
        end else if (cnt_q == CNT_W'(pTIMEOUT - 2)) begin
          ack_d   = gbit;
          dst_d   = ~gbit;
          tout_d  = 1'b1;
          state_d = RESP;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      RESP: begin
        ptr_d   = (bus.omem_pnum == pPNUM_W'(pNUM_PORTS - 1)) ? '0
                                                              : bus.omem_pnum + pPNUM_W'(1);
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State and output registers.
  always_ff @(posedge iclk) begin
    if (irst) begin
      state_q       <= IDLE;
      ptr_q         <= '0;
      cnt_q         <= '0;
      bus.omem_req  <= 1'b0;
      bus.omem_pnum <= '0;
      bus.omem_sa   <= '0;
      bus.omem_da   <= '0;
      bus.oack      <= '0;
      bus.odst_mask <= '0;
      bus.otimeout  <= 1'b0;
    end else begin
      state_q       <= state_d;
      ptr_q         <= ptr_d;
      cnt_q         <= cnt_d;
      bus.omem_req  <= req_d;
      bus.omem_pnum <= grant_d;
      bus.omem_sa   <= sa_d;
      bus.omem_da   <= da_d;
      bus.oack      <= ack_d;
      bus.odst_mask <= dst_d;
      bus.otimeout  <= tout_d;
    end
  end

`ifdef MAC_LOOKUP_ARB_STATS_EN
  // Saturating lookup / timeout counters, bumped once per response.
  always_ff @(posedge iclk) begin
    if (irst) begin
      olookup_cnt  <= '0;
      otimeout_cnt <= '0;
    end else if (state_q == RESP) begin
      if (olookup_cnt != 16'hFFFF) olookup_cnt <= olookup_cnt + 16'd1;
      if (bus.otimeout && (otimeout_cnt != 16'hFFFF)) otimeout_cnt <= otimeout_cnt + 16'd1;
    end
  end
`endif
endmodule

// File: tb/tb_mac_lookup_arb.sv
// Self-checking bench for mac_lookup_arb (4 ports, 48-bit MACs, timeout 16).
// Define MAC_LOOKUP_ARB_STATS_EN to also check the statistics counters.
module tb_mac_lookup_arb;
  localparam int unsigned N  = 4;
  localparam int unsigned W  = 48;
  localparam int unsigned TO = 16;

  logic iclk = 1'b0;
  logic irst = 1'b1;
  int   cyc  = 0;

  mac_lookup_arb_if #(.pNUM_PORTS(N), .pMAC_WIDTH(W)) bus ();

`ifdef MAC_LOOKUP_ARB_STATS_EN
  logic [15:0] olookup_cnt, otimeout_cnt;
`endif

  mac_lookup_arb #(.pNUM_PORTS(N), .pMAC_WIDTH(W), .pTIMEOUT(TO)) dut (
    .iclk         (iclk),
    .irst         (irst),
`ifdef MAC_LOOKUP_ARB_STATS_EN
    .olookup_cnt  (olookup_cnt),
    .otimeout_cnt (otimeout_cnt),
`endif
    .bus          (bus)
  );

  always #5 iclk = ~iclk;
  always @(posedge iclk) cyc <= cyc + 1;

  int          tests = 0;
  int          fails = 0;
  int unsigned ptr_m = 0;     // reference RR pointer
  logic [N-1:0] pend = '0;    // requests still waiting for their ack
  int          lk_m = 0, to_m = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: got %0h, want %0h", tag, obs, exp);
    end
  endtask

  function automatic int unsigned rr_pick(input logic [N-1:0] r, input int unsigned p);
    for (int unsigned k = 0; k < N; k++)
      if (r[(p + k) % N]) return (p + k) % N;
    return 0;
  endfunction

  // One lookup: add newreq to held requests, answer mac_mem with resp d cycles
  // after the strobe (d outside 1..TO-1 means never), check everything.
  task automatic txn(input logic [N-1:0] newreq, input int d, input logic [N-1:0] resp,
                     output int g_obs, output logic [N-1:0] dst_obs, output int ack_cyc);
    logic [N-1:0] rv, em;
    logic [63:0]  mac;
    int unsigned  g;
    bit           normal, seen;
    int           k;
    for (int p = 0; p < int'(N); p++) begin
      if (newreq[p] && !pend[p]) begin
        mac = {$urandom(), $urandom()}; bus.isa[p*W +: W] = mac[W-1:0];
        mac = {$urandom(), $urandom()}; bus.ida[p*W +: W] = mac[W-1:0];
      end
    end
    rv       = pend | newreq;
    bus.ireq = rv;
    g        = rr_pick(rv, ptr_m);
    normal   = (d >= 1) && (d <= int'(TO) - 1);
    em       = (normal && resp != '0) ? resp : '1;
    em       = em & ~(N'(1) << g);
    seen = 1'b0;
    for (int c = 0; c < 20 && !seen; c++) begin
      @(negedge iclk);
      seen = bus.omem_req;
    end
    check("mem_req_seen", 64'(seen), 64'(1));
    check("mem_pnum", 64'(bus.omem_pnum), 64'(g));
    check("mem_sa", 64'(bus.omem_sa), 64'(bus.isa[g*W +: W]));
    check("mem_da", 64'(bus.omem_da), 64'(bus.ida[g*W +: W]));
    g_obs = int'(bus.omem_pnum);
    seen = 1'b0;
    k = 0;
    while (!seen && k < 24) begin
      @(negedge iclk);
      k++;
      if (bus.oack != '0) seen = 1'b1;
      else begin
        bus.imem_ready = (k == d);
        bus.imem_pnum  = (k == d) ? resp : N'($urandom());
      end
    end
    bus.imem_ready = 1'b0;
    check("ack_seen", 64'(seen), 64'(1));
    check("ack", 64'(bus.oack), 64'(N'(1) << g));
    check("dst_mask", 64'(bus.odst_mask), 64'(em));
    check("timeout", 64'(bus.otimeout), 64'(!normal));
    check("latency", 64'(k), 64'(normal ? d + 1 : int'(TO)));
    dst_obs = bus.odst_mask;
    ack_cyc = cyc;
    ptr_m = (g + 1) % N;
    lk_m++;
    if (!normal) to_m++;
    pend = rv & ~(N'(1) << g);
    bus.ireq = pend;
  endtask

  task automatic do_reset();
    @(negedge iclk);
    irst = 1'b1;
    bus.ireq = '0;
    @(negedge iclk);
    @(negedge iclk);
    irst = 1'b0;
    ptr_m = 0; pend = '0; lk_m = 0; to_m = 0;
  endtask

  initial begin
    int g, c0, c1, d;
    logic [N-1:0] dm, nr;
    bus.ireq = '0; bus.isa = '0; bus.ida = '0;
    bus.imem_ready = 1'b0; bus.imem_pnum = '0;

    // Reset values
    @(negedge iclk); @(negedge iclk);
    check("rst_ack", 64'(bus.oack), 64'(0));
    check("rst_req", 64'(bus.omem_req), 64'(0));
    check("rst_pnum", 64'(bus.omem_pnum), 64'(0));
    check("rst_sa", 64'(bus.omem_sa), 64'(0));
    irst = 1'b0;

    // Single request, known DA
    txn(4'b0010, 3, 4'b1000, g, dm, c0);
    check("single_pnum", 64'(g), 64'(1));
    check("single_mask", 64'(dm), 64'(4'b1000));
    @(negedge iclk);
    check("ack_once", 64'(bus.oack), 64'(0));

    // Unknown DA floods, hairpin suppressed
    txn(4'b0100, 2, 4'b0000, g, dm, c0);
    check("unknown_mask", 64'(dm), 64'(4'b1011));
    txn(4'b1000, 1, 4'b1000, g, dm, c0);
    check("hairpin_mask", 64'(dm), 64'(4'b0000));

    // Round robin with all ports requesting
    do_reset();
    c0 = 0;
    for (int i = 0; i < 5; i++) begin
      txn(4'b1111, 1, N'($urandom()), g, dm, c1);
      check("rr_order", 64'(g), 64'(i % 4));
      if (i > 0) check("rr_spacing", 64'(c1 - c0), 64'(4));
      c0 = c1;
    end
    pend = '0; bus.ireq = '0;
    @(negedge iclk);

    // Timeout, and ready on the last WAIT cycle
    txn(4'b0001, 0, 4'b0110, g, dm, c0);
    check("to_mask", 64'(dm), 64'(4'b1110));
    txn(4'b0001, int'(TO) - 1, 4'b0110, g, dm, c0);

    // Reset during WAIT aborts the transaction
    bus.ireq = 4'b0001;
    for (int c = 0; c < 20 && !bus.omem_req; c++) @(negedge iclk);
    @(negedge iclk); @(negedge iclk); @(negedge iclk);
    irst = 1'b1;
    @(negedge iclk);
    check("wrst_ack", 64'(bus.oack), 64'(0));
    check("wrst_mask", 64'(bus.odst_mask), 64'(0));
    check("wrst_tout", 64'(bus.otimeout), 64'(0));
    check("wrst_req", 64'(bus.omem_req), 64'(0));
    check("wrst_pnum", 64'(bus.omem_pnum), 64'(0));
    check("wrst_da", 64'(bus.omem_da), 64'(0));
    irst = 1'b0; bus.ireq = '0;
    ptr_m = 0; pend = '0; lk_m = 0; to_m = 0;
    txn(4'b0100, 2, 4'b0001, g, dm, c0);
    check("post_rst_pnum", 64'(g), 64'(2));

`ifdef MAC_LOOKUP_ARB_STATS_EN
    do_reset();
    for (int i = 0; i < 5; i++)
      txn(N'(1) << (i % 4), (i == 1 || i == 3) ? 0 : i + 1, N'($urandom()), g, dm, c0);
    @(negedge iclk);
    check("stat_lookups", 64'(olookup_cnt), 64'(5));
    check("stat_timeouts", 64'(otimeout_cnt), 64'(2));
    do_reset();
    check("stat_rst_lk", 64'(olookup_cnt), 64'(0));
    check("stat_rst_to", 64'(otimeout_cnt), 64'(0));
`endif

    // Randomized traffic against the reference model
    for (int i = 0; i < 40; i++) begin
      nr = N'($urandom());
      if ((pend | nr) == '0) nr = N'(1) << $urandom_range(0, N - 1);
      d = ($urandom_range(0, 5) == 0) ? 0 : int'($urandom_range(1, TO - 1));
      txn(nr, d, N'($urandom()), g, dm, c0);
    end
`ifdef MAC_LOOKUP_ARB_STATS_EN
    @(negedge iclk);
    check("stat_rand_lk", 64'(olookup_cnt), 64'(lk_m));
    check("stat_rand_to", 64'(otimeout_cnt), 64'(to_m));
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
